// File: rtl/ltcminer_pkg.sv
// Shared constants and types for the LTC miner serial front end.
package ltcminer_pkg;

  localparam int unsigned WORK_BYTES   = 84;
  localparam int unsigned WORK_BITS    = 672;
  localparam logic [15:0] DYNPLL_MAGIC = 16'h55AA;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, falling-edge start detect,
// mid-bit sampling with a single BIT_DIV divider.
module uart_rx_byte
  import ltcminer_pkg::*;
#(
  parameter int unsigned BIT_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       start_ok,
  output logic       rx_idle,
  output logic       start_edge
);

  localparam int unsigned HALF = BIT_DIV / 2;
  localparam int unsigned CW   = $clog2(BIT_DIV + 1);

  logic [1:0]    sync;
  logic          rxd_s;
  logic          rxd_d;
  logic          fall;
  rx_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shreg, sh_nx;

  assign rxd_s      = sync[1];
  assign fall       = rxd_d & ~rxd_s;
  assign rx_idle    = (state == RX_IDLE);
  assign start_edge = rx_idle & fall;
  assign byte_data  = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      rxd_d   <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync    <= {sync[0], rxd};
      rxd_d   <= rxd_s;
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      shreg   <= sh_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    bit_nx     = bit_idx;
    sh_nx      = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    start_ok   = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nx = '0;
        if (fall) state_nx = RX_START;
      end
      RX_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_nx = '0;
          if (rxd_s) begin
            state_nx = RX_IDLE;
          end else begin
            state_nx = RX_DATA;
            bit_nx   = '0;
            start_ok = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (cnt == CW'(BIT_DIV - 1)) begin
          cnt_nx = '0;
          sh_nx  = {rxd_s, shreg[7:1]};
          bit_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        // A low stop bit leaves rxd_d low, so a held break cannot retrigger
        // until the line has returned high.
        if (cnt == CW'(BIT_DIV - 1)) begin
          state_nx = RX_IDLE;
          if (rxd_s) byte_valid = 1'b1;
          else       frame_err  = 1'b1;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/icarus_work_receiver.sv
// Icarus getwork receiver: assembles 84 UART bytes into a 672-bit work unit.
// Optional ICARUS_DYNPLL_EN decodes a 55AA header into pll_cfg/pll_update.
module icarus_work_receiver
  import ltcminer_pkg::*;
#(
  parameter int unsigned comm_clk_frequency = 100_000_000,
  parameter int unsigned baud_rate          = 115_200,
  parameter int unsigned timeout_bits       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [WORK_BITS-1:0] work_data,
  output logic                 work_valid,
  output logic                 rx_error,
`ifdef ICARUS_DYNPLL_EN
  output logic [15:0]          pll_cfg,
  output logic                 pll_update,
`endif
  output logic [6:0]           byte_count
);

  localparam int unsigned BIT_DIV   = comm_clk_frequency / baud_rate;
  localparam int unsigned TO_CYCLES = timeout_bits * BIT_DIV;

  generate
    if (BIT_DIV < 4) begin : g_bad_div
      $error("icarus_work_receiver: comm_clk_frequency/baud_rate must be >= 4");
    end
  endgenerate

  logic [7:0]           byte_data;
  logic                 byte_valid;
  logic                 frame_err;
  logic                 start_ok;
  logic                 rx_idle;
  logic                 start_edge;
  logic [WORK_BITS-1:0] shadow;
  logic [WORK_BITS-1:0] next_unit;
  logic [31:0]          to_cnt;
  logic                 to_expire;

  uart_rx_byte #(
    .BIT_DIV(BIT_DIV)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .start_ok  (start_ok),
    .rx_idle   (rx_idle),
    .start_edge(start_edge)
  );

  assign next_unit = {shadow[WORK_BITS-9:0], byte_data};

  // A start edge arriving on the expiry cycle holds the counter, so the start
  // bit wins; a glitch that aborts back to idle then expires immediately.
  assign to_expire = rx_idle && (byte_count != '0) && !start_edge &&
                     (to_cnt >= TO_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      work_data  <= '0;
      work_valid <= 1'b0;
      rx_error   <= 1'b0;
      byte_count <= '0;
      to_cnt     <= '0;
`ifdef ICARUS_DYNPLL_EN
      pll_cfg    <= 16'h0000;
      pll_update <= 1'b0;
`endif
    end else begin
      work_valid <= 1'b0;
      rx_error   <= 1'b0;
`ifdef ICARUS_DYNPLL_EN
      pll_update <= 1'b0;
`endif
      if (start_ok || byte_count == '0) to_cnt <= '0;
      else if (to_expire)               to_cnt <= '0;
      else if (rx_idle)                 to_cnt <= to_cnt + 32'd1;

      if (frame_err) begin
        rx_error   <= 1'b1;
        byte_count <= '0;
      end else if (byte_valid) begin
        shadow <= next_unit;
        if (byte_count == 7'(WORK_BYTES - 1)) begin
          byte_count <= '0;
          work_data  <= next_unit;
          work_valid <= 1'b1;
`ifdef ICARUS_DYNPLL_EN
          if (next_unit[WORK_BITS-1 -: 16] == DYNPLL_MAGIC) begin
            pll_cfg    <= next_unit[WORK_BITS-17 -: 16];
            pll_update <= 1'b1;
          end
`endif
        end else begin
          byte_count <= byte_count + 7'd1;
        end
      end else if (to_expire) begin
        byte_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_icarus_work_receiver.sv
// Self-checking bench for icarus_work_receiver at 1 MHz / 115200 baud (8 clocks per bit).
module tb_icarus_work_receiver;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int unsigned BD     = CLK_HZ / BAUD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rxd = 1'b1;
  logic [671:0] work_data;
  logic         work_valid;
  logic         rx_error;
  logic [6:0]   byte_count;
`ifdef ICARUS_DYNPLL_EN
  logic [15:0]  pll_cfg;
  logic         pll_update;
`endif

  icarus_work_receiver #(
    .comm_clk_frequency(CLK_HZ),
    .baud_rate         (BAUD),
    .timeout_bits      (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .work_data (work_data),
    .work_valid(work_valid),
    .rx_error  (rx_error),
`ifdef ICARUS_DYNPLL_EN
    .pll_cfg   (pll_cfg),
    .pll_update(pll_update),
`endif
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int           wv_cnt = 0;
  int           err_cnt = 0;
  int           pu_cnt = 0;
  int           pu_lone = 0;
  logic [671:0] last_work = '0;
  logic [7:0]   unit [84];

  always @(negedge clk) begin
    if (work_valid) begin
      wv_cnt    = wv_cnt + 1;
      last_work = work_data;
    end
    if (rx_error) err_cnt = err_cnt + 1;
`ifdef ICARUS_DYNPLL_EN
    if (pll_update) begin
      pu_cnt = pu_cnt + 1;
      if (!work_valid) pu_lone = pu_lone + 1;
    end
`endif
  end

  function automatic logic [671:0] expected_vec();
    logic [671:0] v;
    v = '0;
    for (int unsigned i = 0; i < 84; i++) v[671 - 8*i -: 8] = unit[i];
    return v;
  endfunction

  task automatic fill_random();
    for (int unsigned i = 0; i < 84; i++) unit[i] = 8'($urandom);
    unit[0] = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(posedge clk); #1 rxd = 1'b0;
    for (int unsigned b = 0; b < 8; b++) begin
      repeat (BD) @(posedge clk);
      #1 rxd = d[b];
    end
    repeat (BD) @(posedge clk);
    #1 rxd = stop;
    repeat (BD) @(posedge clk);
    #1 rxd = 1'b1;
  endtask

  task automatic send_unit();
    for (int unsigned i = 0; i < 84; i++) send_byte(unit[i], 1'b1);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_unit(input string name, input int wv0);
    checks++;
    if (wv_cnt - wv0 !== 1) begin
      errors++;
      $display("FAIL %s_valid_count got=%0d want=1", name, wv_cnt - wv0);
    end
    checks++;
    if (last_work !== expected_vec()) begin
      errors++;
      $display("FAIL %s_data got=%h want=%h", name, last_work, expected_vec());
    end
    checks++;
    if (byte_count !== 7'd0) begin
      errors++;
      $display("FAIL %s_byte_count got=%0d want=0", name, byte_count);
    end
  endtask

  task automatic test_reset();
    idle(4);
    checks++;
    if (work_data !== '0 || work_valid !== 1'b0 || rx_error !== 1'b0 || byte_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got wd=%h wv=%b err=%b bc=%0d want all zero",
               work_data[31:0], work_valid, rx_error, byte_count);
    end
`ifdef ICARUS_DYNPLL_EN
    checks++;
    if (pll_cfg !== 16'h0000 || pll_update !== 1'b0) begin
      errors++;
      $display("FAIL reset_pll got cfg=%h upd=%b want 0000/0", pll_cfg, pll_update);
    end
`endif
    #1 rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_vector();
    int wv0, e0, p0;
    fill_random();
    unit[0] = 8'h00; unit[1] = 8'h00; unit[2] = 8'h07; unit[3] = 8'hff;
    unit[4] = 8'h00; unit[5] = 8'h00; unit[6] = 8'h31; unit[7] = 8'h8e;
    unit[80] = 8'h01; unit[81] = 8'h00; unit[82] = 8'h00; unit[83] = 8'h00;
    wv0 = wv_cnt; e0 = err_cnt; p0 = pu_cnt;
    send_byte(unit[0], 1'b1);
    send_byte(unit[1], 1'b1);
    idle(2);
    checks++;
    if (byte_count !== 7'd2) begin
      errors++;
      $display("FAIL vector_partial_count got=%0d want=2", byte_count);
    end
    for (int unsigned i = 2; i < 84; i++) send_byte(unit[i], 1'b1);
    idle(4);
    check_unit("vector", wv0);
    checks++;
    if (err_cnt != e0 || pu_cnt != p0) begin
      errors++;
      $display("FAIL vector_side_strobes got err=%0d pll=%0d want 0/0", err_cnt - e0, pu_cnt - p0);
    end
    idle(20 * BD);
    checks++;
    if (work_data !== expected_vec()) begin
      errors++;
      $display("FAIL vector_hold got=%h want=%h", work_data[31:0], expected_vec()[31:0]);
    end
  endtask

  task automatic test_dynpll();
    int wv0, p0;
    fill_random();
    unit[0] = 8'h55; unit[1] = 8'haa; unit[2] = 8'h07; unit[3] = 8'hff;
    wv0 = wv_cnt; p0 = pu_cnt;
    send_unit();
    idle(4);
    check_unit("dynpll", wv0);
`ifdef ICARUS_DYNPLL_EN
    checks++;
    if (pu_cnt - p0 !== 1 || pu_lone !== 0) begin
      errors++;
      $display("FAIL dynpll_update got=%0d lone=%0d want 1/0", pu_cnt - p0, pu_lone);
    end
    checks++;
    if (pll_cfg !== 16'h07FF) begin
      errors++;
      $display("FAIL dynpll_cfg got=%h want=07ff", pll_cfg);
    end
`else
    checks++;
    if (pu_cnt != p0) begin
      errors++;
      $display("FAIL dynpll_absent got=%0d want=0", pu_cnt - p0);
    end
`endif
  endtask

  task automatic test_frame_error();
    int wv0, e0;
    fill_random();
    wv0 = wv_cnt; e0 = err_cnt;
    for (int unsigned i = 0; i < 39; i++) send_byte(8'($urandom), 1'b1);
    idle(2);
    checks++;
    if (byte_count !== 7'd39) begin
      errors++;
      $display("FAIL frame_partial_count got=%0d want=39", byte_count);
    end
    send_byte(8'($urandom), 1'b0);
    idle(3 * BD);
    checks++;
    if (err_cnt - e0 !== 1 || byte_count !== 7'd0 || wv_cnt != wv0) begin
      errors++;
      $display("FAIL frame_error got err=%0d bc=%0d wv=%0d want 1/0/0",
               err_cnt - e0, byte_count, wv_cnt - wv0);
    end
    send_unit();
    idle(4);
    check_unit("frame_recover", wv0);
  endtask

  task automatic test_timeout();
    int wv0, e0;
    fill_random();
    e0 = err_cnt;
    for (int unsigned i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1);
    idle(20 * BD);
    checks++;
    if (byte_count !== 7'd10) begin
      errors++;
      $display("FAIL timeout_early got=%0d want=10", byte_count);
    end
    idle(20 * BD);
    checks++;
    if (byte_count !== 7'd0 || err_cnt != e0) begin
      errors++;
      $display("FAIL timeout_expire got bc=%0d err=%0d want 0/0", byte_count, err_cnt - e0);
    end
    wv0 = wv_cnt;
    send_unit();
    idle(4);
    check_unit("timeout_recover", wv0);
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_cnt;
    for (int unsigned i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    idle(12 * BD);
    checks++;
    if (byte_count !== 7'd5 || err_cnt != e0) begin
      errors++;
      $display("FAIL glitch got bc=%0d err=%0d want 5/0", byte_count, err_cnt - e0);
    end
    idle(40 * BD);
  endtask

  task automatic test_break();
    int e0;
    e0 = err_cnt;
    @(posedge clk); #1 rxd = 1'b0;
    idle(30 * BD);
    checks++;
    if (err_cnt - e0 !== 1 || byte_count !== 7'd0) begin
      errors++;
      $display("FAIL break got err=%0d bc=%0d want 1/0", err_cnt - e0, byte_count);
    end
    #1 rxd = 1'b1;
    idle(4 * BD);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL break_release got err=%0d want 1", err_cnt - e0);
    end
  endtask

  task automatic test_reset_midunit();
    int wv0;
    for (int unsigned i = 0; i < 50; i++) send_byte(8'($urandom), 1'b1);
    idle(2);
    checks++;
    if (byte_count !== 7'd50) begin
      errors++;
      $display("FAIL midreset_partial got=%0d want=50", byte_count);
    end
    @(posedge clk); #1 rxd = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    idle(3);
    checks++;
    if (work_data !== '0 || work_valid !== 1'b0 || rx_error !== 1'b0 || byte_count !== 7'd0) begin
      errors++;
      $display("FAIL midreset_outputs got wd=%h wv=%b err=%b bc=%0d want all zero",
               work_data[31:0], work_valid, rx_error, byte_count);
    end
    #1 rxd = 1'b1;
    idle(3);
    #1 rst_n = 1'b1;
    idle(4);
    fill_random();
    wv0 = wv_cnt;
    send_unit();
    idle(4);
    check_unit("midreset_recover", wv0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vector();
    test_dynpll();
    test_frame_error();
    test_timeout();
    test_glitch();
    test_break();
    test_reset_midunit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
